// File: rtl/uart_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : uart_pkg
// Brief  : Shared UART constants and the receive state encoding.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
package uart_pkg;

  // 100 MHz system clock divided down to 115200 baud
  localparam int CLKS_PER_BIT_115200 = 868;

  // 8N1 frame: eight data bits per frame
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_deframer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : uart_rx_deframer_if
// Brief  : Serial input and received-byte outputs of the UART receive stage.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
interface uart_rx_deframer_if;
  import uart_pkg::*;

  logic                 rx_serial;
  logic                 r_DV;
  logic [DATA_BITS-1:0] r_byte;
  logic                 framing_err;
  logic                 busy;

  // Line driver / byte consumer side
  modport master (
    output rx_serial,
    input  r_DV,
    input  r_byte,
    input  framing_err,
    input  busy
  );

  // Receiver side
  modport slave (
    input  rx_serial,
    output r_DV,
    output r_byte,
    output framing_err,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : sync_ff
// Brief  : STAGES-deep flop chain for bringing an asynchronous input into the
//          clk domain. Reset value is selectable so idle-high lines look idle.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d,
  output logic      q
);

  logic [STAGES-1:0] chain;

  // Shift the async input through the chain; oldest sample exits at the top
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_deframer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : uart_rx_deframer
// Brief  : UART 8N1 receiver. Oversamples the synchronized serial line, checks
//          the start bit at its midpoint, samples each data bit mid-bit and
//          strobes either r_DV (good stop bit) or framing_err (stop bit low).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int SYNC_STAGES  = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  uart_rx_deframer_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  // Start bit is confirmed halfway in; from there each full bit period lands
  // on the middle of the next bit.
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                 rx;
  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift;
  logic                 dv;
  logic                 ferr;
  logic [DATA_BITS-1:0] byte_q;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx_serial),
    .q   (rx)
  );

  // Frame recovery FSM with registered strobes and byte output
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shift  <= '0;
      dv     <= 1'b0;
      ferr   <= 1'b0;
      byte_q <= '0;
    end else begin
      dv   <= 1'b0;
      ferr <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_CNT) begin
            cnt <= '0;
            idx <= '0;
            // A line that is already high again was a glitch, not a start bit
            state <= rx ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt        <= '0;
            shift[idx] <= rx;
            if (idx == LAST_IDX) begin
              state <= STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (rx) begin
              byte_q <= shift;
              dv     <= 1'b1;
              state  <= IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= BREAK_WAIT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK_WAIT: begin
          // Hold off until the line returns high so a break is one error only
          if (rx) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.r_DV        = dv;
  assign bus.r_byte      = byte_q;
  assign bus.framing_err = ferr;
  assign bus.busy        = (state != IDLE);

endmodule
`default_nettype wire

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- UART receive stage: oversamples the asynchronous serial line, recovers 8N1 frames and presents each byte with a one-cycle data-valid strobe `r_DV`.
- Sits directly upstream of the LED/pulse-stretch stage, which consumes `r_DV`; `r_byte` also feeds the downstream byte consumers.
- Also flags framing errors and rejects start-bit glitches.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200). Legal range 4..65535.
- SYNC_STAGES, 2, flip-flop stages on rx_serial before use. Legal range 2..3.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- rx_serial  in  1  asynchronous serial line, idle high
- r_DV  out  1  one-cycle strobe: r_byte holds a newly received valid byte
- r_byte  out  8  last correctly framed byte, LSB received first
- framing_err  out  1  one-cycle strobe: stop bit sampled low
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; bit counter=0; bit index=0.
  - Synchronizer flops set to 1 (line idle).
  - r_DV=0, framing_err=0, busy=0, r_byte=8'h00.
  - Reset mid-frame aborts the frame with no strobe.
- Synchronizer: rx_serial passes through SYNC_STAGES flops; "rx" below means the synchronized value. Total input latency is SYNC_STAGES cycles.
- Bit counter: width $clog2(CLKS_PER_BIT). HALF = (CLKS_PER_BIT-1)/2 (integer divide).
- IDLE: when rx==0, go to START and clear the counter.
- START:
  - Count up to HALF.
  - At HALF, if rx==0: go to DATA, clear the counter, set bit index=0.
  - At HALF, if rx==1: treat as a glitch and return to IDLE; no strobe.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx into shift[bit index] and clear the counter.
  - After index 7 is sampled, go to STOP; otherwise increment the index.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rx.
  - rx==1: r_byte<=shift, r_DV<=1 for exactly one cycle, go to IDLE.
  - rx==0: framing_err<=1 for exactly one cycle, r_byte unchanged, no r_DV, go to BREAK_WAIT.
- BREAK_WAIT: stay until rx==1, then go to IDLE. This prevents a held-low line (break) from re-triggering as start bits.
- Timing:
  - Every bit is sampled at its midpoint ±1 cycle.
  - r_DV rises 1 cycle after the mid-stop-bit sample, i.e. about 9.5 bit times + SYNC_STAGES + 1 cycles after the start-bit falling edge.
- Back-to-back frames: IDLE is reached mid-stop-bit, so a start edge immediately after the stop bit is caught with no byte lost.
- r_DV and framing_err are mutually exclusive and never asserted for two consecutive cycles.
- r_byte is stable except in the cycle r_DV is asserted.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants: IDLE, START, DATA, STOP, BREAK_WAIT (3-bit)
  - default CLKS_PER_BIT_115200 = 868
  - frame constant DATA_BITS = 8
- One natural sub-module: sync_ff, the parameterised SYNC_STAGES-deep synchronizer with reset value 1, reusable for other async inputs (buttons, switches).

Test Plan (CLKS_PER_BIT=16, SYNC_STAGES=2):
- Single frame 8'hA5 with stop=1 -> exactly one r_DV pulse, r_byte=8'hA5, framing_err=0, busy=0 afterwards.
- Back-to-back frames 8'h00, 8'hFF, 8'h3C with no idle gap -> three r_DV pulses, bytes in order, none dropped.
- Start glitch: line low for 5 cycles, then high -> return to IDLE, no r_DV or framing_err; a following frame 8'h81 is received correctly.
- Framing error: frame 8'h55 with stop=0, line held low 40 cycles, then high, then frame 8'h12 -> one framing_err pulse; r_byte stays at its prior value; no spurious frames during the low period; then r_DV with r_byte=8'h12.
- Reset mid-frame: assert rst for 1 cycle during data bit 4 of 8'hC3 -> no strobe, busy=0 the next cycle, next full frame 8'h7E received correctly.
- Baud tolerance: frames sent at CLKS_PER_BIT ±3% (15.5/16.5 cycle bits) -> all bytes received correctly.
